// File: rtl/axi_lite_rd_ctrl.sv
// AXI4-Lite read controller: queues AR requests, runs one memory read at a time and returns RDATA/RRESP in order.
// Latency: OKAY RVALID 3+RD_LATENCY cycles after AR handshake, SLVERR 2; ARREADY falls when the queue fills, R holds until RREADY.

module axi_lite_rd_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full_next
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign pop_dat   = mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign full_next = (cnt_next == FULL_CNT);

  always_comb begin
    cnt_next = cnt;
    if (push_vld && !pop_rdy)
      cnt_next = cnt + 1'b1;
    else if (!push_vld && pop_rdy)
      cnt_next = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_vld)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_next;
      if (push_vld)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop_rdy)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end
endmodule

module axi_lite_rd_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 6,
  parameter int MEM_DEPTH     = 16,
  parameter int RD_LATENCY    = 1,
  parameter int AR_FIFO_DEPTH = 2,
  localparam int BYTE_BITS    = $clog2(DATA_WIDTH / 8),
  localparam int WORD_AW      = ADDR_WIDTH - BYTE_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  input  logic                  RREADY,
  output logic                  MEM_RD_EN,
  output logic [WORD_AW-1:0]    MEM_RD_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_RD_DATA
);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  LAT_LOAD    = 2'(RD_LATENCY - 1);
  localparam logic [31:0] MEM_DEPTH_U = MEM_DEPTH;

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

  state_t               state;
  logic [1:0]           lat_cnt;
  logic                 ar_push;
  logic [WORD_AW-1:0]   ar_idx;
  logic                 ar_err;
  logic                 hd_pop;
  logic [WORD_AW:0]     head_dat;
  logic                 fifo_empty;
  logic                 fifo_full_next;

  assign ar_push = ARVALID && ARREADY;
  assign ar_idx  = ARADDR[ADDR_WIDTH-1:BYTE_BITS];
  assign ar_err  = (ARADDR[BYTE_BITS-1:0] != '0) || (32'(ar_idx) >= MEM_DEPTH_U);
  assign hd_pop  = (state == IDLE) && !fifo_empty;

  // Each entry carries the word index plus its precomputed error flag.
  axi_lite_rd_ctrl_fifo #(
    .WIDTH (WORD_AW + 1),
    .DEPTH (AR_FIFO_DEPTH)
  ) u_ar_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push_vld  (ar_push),
    .push_dat  ({ar_err, ar_idx}),
    .pop_rdy   (hd_pop),
    .pop_dat   (head_dat),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ARREADY     <= 1'b0;
      RVALID      <= 1'b0;
      RDATA       <= '0;
      RRESP       <= RESP_OKAY;
      MEM_RD_EN   <= 1'b0;
      MEM_RD_ADDR <= '0;
      lat_cnt     <= '0;
    end else begin
      ARREADY   <= !fifo_full_next;
      MEM_RD_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_dat[WORD_AW]) begin
              RVALID <= 1'b1;
              RRESP  <= RESP_SLVERR;
              RDATA  <= '0;
              state  <= RESP;
            end else begin
              MEM_RD_EN   <= 1'b1;
              MEM_RD_ADDR <= head_dat[WORD_AW-1:0];
              state       <= READ;
            end
          end
        end
        READ: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          // Counter hits zero in the cycle the memory data is valid.
          if (lat_cnt == 2'd0) begin
            RDATA  <= MEM_RD_DATA;
            RRESP  <= RESP_OKAY;
            RVALID <= 1'b1;
            state  <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_rd_ctrl.sv
// Bench: two controller instances (defaults, and MEM_DEPTH=12/RD_LATENCY=3) checked against an in-order response model.
module tb_axi_lite_rd_ctrl;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] arvalid;
  logic [1:0] rready;
  logic [1:0][5:0] araddr;
  wire  [1:0] arready;
  wire  [1:0] rvalid;
  wire  [1:0] mem_rd_en;
  wire  [1:0][31:0] rdata;
  wire  [1:0][31:0] mem_rd_data;
  wire  [1:0][1:0] rresp;
  wire  [1:0][3:0] mem_rd_addr;

  logic [31:0] mem [2][16];
  logic [1:0][3:0] en_pipe = '0;
  logic [3:0] apipe [2][4];

  exp_t exp_q [2][$];
  logic [3:0] stb_q [2][$];
  logic [1:0] stalled = '0;

  int vectors = 0;
  int miscompares = 0;
  logic hs;

  always #5 clk = ~clk;

  axi_lite_rd_ctrl u_dut_a (
    .CLK(clk), .RST(rst[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]), .ARADDR(araddr[0]),
    .RVALID(rvalid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RREADY(rready[0]),
    .MEM_RD_EN(mem_rd_en[0]), .MEM_RD_ADDR(mem_rd_addr[0]), .MEM_RD_DATA(mem_rd_data[0])
  );

  axi_lite_rd_ctrl #(.MEM_DEPTH(12), .RD_LATENCY(LAT_B)) u_dut_b (
    .CLK(clk), .RST(rst[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]), .ARADDR(araddr[1]),
    .RVALID(rvalid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RREADY(rready[1]),
    .MEM_RD_EN(mem_rd_en[1]), .MEM_RD_ADDR(mem_rd_addr[1]), .MEM_RD_DATA(mem_rd_data[1])
  );

  // Memory: data is only valid exactly RD_LATENCY cycles after a strobe, junk otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      en_pipe[d]  <= {en_pipe[d][2:0], mem_rd_en[d]};
      apipe[d][0] <= mem_rd_addr[d];
      for (int k = 1; k < 4; k++) apipe[d][k] <= apipe[d][k-1];
    end
  end
  assign mem_rd_data[0] = en_pipe[0][LAT_A-1] ? mem[0][apipe[0][LAT_A-1]] : JUNK;
  assign mem_rd_data[1] = en_pipe[1][LAT_B-1] ? mem[1][apipe[1][LAT_B-1]] : JUNK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ref_resp(input int d, input logic [5:0] a);
    exp_t e;
    int idx;
    int depth;
    idx = int'(a) / 4;
    depth = (d == 0) ? 16 : 12;
    if ((int'(a) % 4) != 0 || idx >= depth) begin
      e.resp = 2'b10;
      e.data = '0;
    end else begin
      e.resp = 2'b00;
      e.data = mem[d][idx];
    end
    return e;
  endfunction

  // Scoreboard: expected responses in AR acceptance order, strobes only for OKAY entries.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        exp_q[d].delete();
        stb_q[d].delete();
        stalled[d] = 1'b0;
      end else begin
        if (arvalid[d] && arready[d]) begin
          exp_t e;
          e = ref_resp(d, araddr[d]);
          exp_q[d].push_back(e);
          if (e.resp == 2'b00) stb_q[d].push_back(araddr[d][5:2]);
        end
        if (mem_rd_en[d]) begin
          chk("mem_rd_en_unexpected", mem_rd_en[d], stb_q[d].size() != 0);
          if (stb_q[d].size() != 0) chk("mem_rd_addr", mem_rd_addr[d], stb_q[d].pop_front());
        end
        if (stalled[d]) chk("rvalid_dropped_before_rready", rvalid[d], 1'b1);
        if (rvalid[d]) begin
          chk("rvalid_unexpected", rvalid[d], exp_q[d].size() != 0);
          if (exp_q[d].size() != 0) begin
            chk("rresp", rresp[d], exp_q[d][0].resp);
            chk("rdata", rdata[d], exp_q[d][0].data);
            if (rready[d]) void'(exp_q[d].pop_front());
          end
        end
        stalled[d] = rvalid[d] && !rready[d];
      end
    end
  end

  task automatic drain(input int d, input string tag);
    rready[d] = 1'b1;
    for (int i = 0; i < 300 && (exp_q[d].size() != 0 || rvalid[d]); i++) step();
    chk({tag, "_responses_outstanding"}, exp_q[d].size(), 0);
    chk({tag, "_strobes_outstanding"}, stb_q[d].size(), 0);
    rready[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed still running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 2'b11; arvalid = 2'b11; rready = 2'b00;
    araddr[0] = 6'h00; araddr[1] = 6'h00;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mem[d][i] = $urandom;
    mem[0][2] = 32'hDEAD_BEEF;

    // Reset held two cycles with ARVALID high.
    for (int c = 0; c < 2; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        chk("rst_arready", arready[d], 1'b0);
        chk("rst_rvalid", rvalid[d], 1'b0);
        chk("rst_mem_rd_en", mem_rd_en[d], 1'b0);
        chk("rst_mem_rd_addr", mem_rd_addr[d], 4'h0);
        chk("rst_rdata", rdata[d], 32'h0);
        chk("rst_rresp", rresp[d], 2'b00);
      end
    end
    rst = 2'b00; arvalid = 2'b00;
    step();
    chk("arready_after_release_a", arready[0], 1'b1);
    chk("arready_after_release_b", arready[1], 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("no_resp_after_reset", rvalid[0], 1'b0);
      chk("no_strobe_after_reset", mem_rd_en[0], 1'b0);
      step();
    end

    // Single read, default parameters.
    araddr[0] = 6'h08; arvalid[0] = 1'b1;
    chk("single_arready", arready[0], 1'b1);
    step(); arvalid[0] = 1'b0;
    chk("single_en_c1", mem_rd_en[0], 1'b0);
    step();
    chk("single_en_c2", mem_rd_en[0], 1'b1);
    chk("single_addr_c2", mem_rd_addr[0], 4'd2);
    step();
    chk("single_en_c3", mem_rd_en[0], 1'b0);
    chk("single_rvalid_c3", rvalid[0], 1'b0);
    step();
    chk("single_rvalid_c4", rvalid[0], 1'b1);
    chk("single_rdata_c4", rdata[0], 32'hDEAD_BEEF);
    chk("single_rresp_c4", rresp[0], 2'b00);
    rready[0] = 1'b1;
    step();
    chk("single_rvalid_clear", rvalid[0], 1'b0);
    rready[0] = 1'b0;

    // Backpressure: RREADY low, four addresses offered back to back.
    arvalid[0] = 1'b1; araddr[0] = 6'h00;
    chk("bp_ready_c0", arready[0], 1'b1);
    step(); chk("bp_ready_c1", arready[0], 1'b1); araddr[0] = 6'h04;
    step(); chk("bp_ready_c2", arready[0], 1'b1); araddr[0] = 6'h08;
    step(); araddr[0] = 6'h0C;
    for (int c = 0; c < 10; c++) begin
      chk("bp_full_arready", arready[0], 1'b0);
      step();
    end
    chk("bp_rvalid_stalled", rvalid[0], 1'b1);
    rready[0] = 1'b1;
    step();
    chk("bp_arready_before_pop", arready[0], 1'b0);
    step();
    chk("bp_arready_after_pop", arready[0], 1'b1);
    step(); arvalid[0] = 1'b0;
    drain(0, "bp");

    // SLVERR: out of range (MEM_DEPTH=12) and misaligned.
    for (int k = 0; k < 2; k++) begin
      araddr[1] = (k == 0) ? 6'h30 : 6'h05; arvalid[1] = 1'b1;
      chk("err_arready", arready[1], 1'b1);
      step(); arvalid[1] = 1'b0;
      chk("err_rvalid_c1", rvalid[1], 1'b0);
      chk("err_en_c1", mem_rd_en[1], 1'b0);
      step();
      chk("err_rvalid_c2", rvalid[1], 1'b1);
      chk("err_rresp_c2", rresp[1], 2'b10);
      chk("err_rdata_c2", rdata[1], 32'h0);
      chk("err_en_c2", mem_rd_en[1], 1'b0);
      rready[1] = 1'b1;
      step();
      chk("err_rvalid_clear", rvalid[1], 1'b0);
      rready[1] = 1'b0;
    end

    // Random mixed stream with random RREADY, RD_LATENCY=3.
    for (int cyc = 0; cyc < 500; cyc++) begin
      hs = arvalid[1] && arready[1];
      rready[1] = 1'($urandom_range(0, 1));
      step();
      if (hs || !arvalid[1]) begin
        arvalid[1] = 1'($urandom_range(0, 1));
        araddr[1] = ($urandom_range(0, 3) != 0) ? {4'($urandom_range(0, 11)), 2'b00} : 6'($urandom);
      end
    end
    arvalid[1] = 1'b0;
    drain(1, "rand");

    // Reset while the first read waits and a second is queued.
    araddr[1] = 6'h04; arvalid[1] = 1'b1;
    chk("rw_arready_c0", arready[1], 1'b1);
    step(); araddr[1] = 6'h08;
    chk("rw_arready_c1", arready[1], 1'b1);
    step(); arvalid[1] = 1'b0;
    chk("rw_strobe_c2", mem_rd_en[1], 1'b1);
    step();
    rst[1] = 1'b1;
    step();
    chk("rw_rst_rvalid", rvalid[1], 1'b0);
    chk("rw_rst_en", mem_rd_en[1], 1'b0);
    chk("rw_rst_arready", arready[1], 1'b0);
    chk("rw_rst_rdata", rdata[1], 32'h0);
    chk("rw_rst_rresp", rresp[1], 2'b00);
    rst[1] = 1'b0;
    step();
    chk("rw_arready_release", arready[1], 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("rw_no_resp", rvalid[1], 1'b0);
      chk("rw_no_strobe", mem_rd_en[1], 1'b0);
      step();
    end
    araddr[1] = 6'h0C; arvalid[1] = 1'b1;
    step(); arvalid[1] = 1'b0;
    step();
    chk("rw_next_en_c2", mem_rd_en[1], 1'b1);
    chk("rw_next_addr_c2", mem_rd_addr[1], 4'd3);
    step(); step(); step();
    chk("rw_next_rvalid_c5", rvalid[1], 1'b0);
    step();
    chk("rw_next_rvalid_c6", rvalid[1], 1'b1);
    chk("rw_next_rdata_c6", rdata[1], mem[1][3]);
    chk("rw_next_rresp_c6", rresp[1], 2'b00);
    rready[1] = 1'b1;
    step();
    chk("rw_next_rvalid_clear", rvalid[1], 1'b0);
    rready[1] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
